// File: rtl/btb_next_pc.sv
// Next-PC generator with a direct-mapped branch target buffer.
// The table lookup is combinational at IF. EX branch resolution redirects the
// PC on a mispredict, and the table is trained at the rising edge.
// Ports:
//   clk_i, rst_i               clock and async active-low reset
//   fetch_pc_i, stall_i        current IF address and hazard hold request
//   next_pc_o, if_redo_o       next PC value and PC hold
//   pred_taken_o/target_o      IF prediction, carried down the pipe
//   ex_*_i                     resolved branch feedback from EX
//   flush_o                    squash IF/ID and ID/EX on mispredict
//   mispredict_cnt_o           free-running mispredict counter (wraps)
module btb_next_pc #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned TAG_W   = 32 - IDX_W - 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        stall_i,
  output logic [31:0] next_pc_o,
  output logic        if_redo_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic        flush_o,
  output logic [31:0] mispredict_cnt_o
);

  localparam int unsigned CTR_W = 2;

  // BTB storage
  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [31:0]       tgt_q   [ENTRIES];
  logic [CTR_W-1:0]  ctr_q   [ENTRIES];
  logic [31:0]       cnt_q, cnt_d;

  logic [IDX_W-1:0]  f_idx, e_idx;
  logic [TAG_W-1:0]  f_tag, e_tag;
  logic              f_hit, e_hit;
  logic [31:0]       fetch_seq, ex_seq, actual, predicted;
  logic              mispredict;

  // Entry write for this cycle's training
  logic              upd_en;
  logic              upd_valid;
  logic [TAG_W-1:0]  upd_tag;
  logic [31:0]       upd_tgt;
  logic [CTR_W-1:0]  upd_ctr;

  assign f_idx = fetch_pc_i[IDX_W+1:2];
  assign f_tag = fetch_pc_i[31:IDX_W+2];
  assign e_idx = ex_pc_i[IDX_W+1:2];
  assign e_tag = ex_pc_i[31:IDX_W+2];

  // Lookup, resolution and next-PC selection
  always_comb begin
    fetch_seq     = fetch_pc_i + 32'd4;
    ex_seq        = ex_pc_i + 32'd4;
    f_hit         = valid_q[f_idx] & (tag_q[f_idx] == f_tag);
    pred_taken_o  = f_hit & ctr_q[f_idx][1];
    pred_target_o = f_hit ? tgt_q[f_idx] : fetch_seq;

    actual     = ex_taken_i ? ex_target_i : ex_seq;
    predicted  = ex_pred_taken_i ? ex_pred_target_i : ex_seq;
    mispredict = ex_valid_i & ((ex_is_branch_i & (actual != predicted)) |
                               (~ex_is_branch_i & ex_pred_taken_i));
    flush_o    = mispredict;

    // A redirect always wins over a stall
    if (mispredict)        next_pc_o = ex_is_branch_i ? actual : ex_seq;
    else if (stall_i)      next_pc_o = fetch_pc_i;
    else if (pred_taken_o) next_pc_o = pred_target_o;
    else                   next_pc_o = fetch_seq;
    if_redo_o = stall_i & ~mispredict;

    cnt_d            = mispredict ? cnt_q + 32'd1 : cnt_q;
    mispredict_cnt_o = cnt_q;
  end

  // Training decision for the EX instruction's entry
  always_comb begin
    e_hit     = valid_q[e_idx] & (tag_q[e_idx] == e_tag);
    upd_en    = 1'b0;
    upd_valid = valid_q[e_idx];
    upd_tag   = tag_q[e_idx];
    upd_tgt   = tgt_q[e_idx];
    upd_ctr   = ctr_q[e_idx];
    if (ex_valid_i) begin
      if (ex_is_branch_i) begin
        if (e_hit) begin
          upd_en = 1'b1;
          if (ex_taken_i) begin
            upd_tgt = ex_target_i;
            if (ctr_q[e_idx] != 2'b11) upd_ctr = ctr_q[e_idx] + 2'd1;
          end else begin
            if (ctr_q[e_idx] != 2'b00) upd_ctr = ctr_q[e_idx] - 2'd1;
          end
        end else if (ex_taken_i) begin
          // Allocate or replace, starting weakly taken
          upd_en    = 1'b1;
          upd_valid = 1'b1;
          upd_tag   = e_tag;
          upd_tgt   = ex_target_i;
          upd_ctr   = 2'b10;
        end
      end else if (ex_pred_taken_i && e_hit) begin
        // Non-branch aliased onto a BTB entry: drop it
        upd_en    = 1'b1;
        upd_valid = 1'b0;
      end
    end
  end

  // Table and counter state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (upd_en) begin
        valid_q[e_idx] <= upd_valid;
        tag_q[e_idx]   <= upd_tag;
        tgt_q[e_idx]   <= upd_tgt;
        ctr_q[e_idx]   <= upd_ctr;
      end
    end
  end

endmodule

// File: tb/tb_btb_next_pc.sv
// Directed bench for btb_next_pc: the driver pushes hand-computed expectations
// into a queue, and a negedge monitor pops and compares each output set.
module tb_btb_next_pc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] fetch_pc_i;
  logic        stall_i;
  logic [31:0] next_pc_o;
  logic        if_redo_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_valid_i;
  logic        ex_is_branch_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        flush_o;
  logic [31:0] mispredict_cnt_o;

  btb_next_pc dut (
    .clk_i(clk_i), .rst_i(rst_i), .fetch_pc_i(fetch_pc_i), .stall_i(stall_i),
    .next_pc_o(next_pc_o), .if_redo_o(if_redo_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .ex_valid_i(ex_valid_i),
    .ex_is_branch_i(ex_is_branch_i), .ex_pc_i(ex_pc_i), .ex_taken_i(ex_taken_i),
    .ex_target_i(ex_target_i), .ex_pred_taken_i(ex_pred_taken_i),
    .ex_pred_target_i(ex_pred_target_i), .flush_o(flush_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] next_pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        flush;
    logic        redo;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk32(input string name, input string fld,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got 0x%08h required 0x%08h", name, fld, act, req);
  endtask

  // Monitor: compare whatever the driver has queued for this cycle
  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk32(e.name, "next_pc",  next_pc_o,                e.next_pc);
      chk32(e.name, "pred_tk",  32'(pred_taken_o),        32'(e.pt));
      chk32(e.name, "pred_tgt", pred_target_o,            e.ptgt);
      chk32(e.name, "flush",    32'(flush_o),             32'(e.flush));
      chk32(e.name, "redo",     32'(if_redo_o),           32'(e.redo));
      chk32(e.name, "cnt",      mispredict_cnt_o,         e.cnt);
    end
  end

  task automatic drive(input logic [31:0] fpc, input logic stall,
                       input logic exv, input logic exb, input logic [31:0] expc,
                       input logic ext, input logic [31:0] extgt,
                       input logic expt, input logic [31:0] exptgt);
    fetch_pc_i = fpc; stall_i = stall; ex_valid_i = exv; ex_is_branch_i = exb;
    ex_pc_i = expc; ex_taken_i = ext; ex_target_i = extgt;
    ex_pred_taken_i = expt; ex_pred_target_i = exptgt;
  endtask

  task automatic expect_out(input string name, input logic [31:0] npc,
                            input logic pt, input logic [31:0] ptgt,
                            input logic fl, input logic rd, input logic [31:0] cnt);
    exp_t e;
    e.name = name; e.next_pc = npc; e.pt = pt; e.ptgt = ptgt;
    e.flush = fl; e.redo = rd; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;

    //        fetch     st  exv exb ex_pc     tk  tgt       ptk ptgt
    drive(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    expect_out("reset",      32'h104, 0, 32'h104, 0, 0, 32'd0);
    step(); drive(32'h100, 0, 1, 1, 32'h100, 1, 32'h200, 0, 32'h0);
    expect_out("alloc",      32'h200, 0, 32'h104, 1, 0, 32'd0);
    step(); drive(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    expect_out("hit",        32'h200, 1, 32'h200, 0, 0, 32'd1);
    step(); drive(32'h100, 0, 1, 1, 32'h100, 0, 32'h200, 1, 32'h200);
    expect_out("nt1",        32'h104, 1, 32'h200, 1, 0, 32'd1);
    step(); drive(32'h100, 0, 1, 1, 32'h100, 0, 32'h200, 0, 32'h0);
    expect_out("nt2",        32'h104, 0, 32'h200, 0, 0, 32'd2);
    step(); drive(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    expect_out("weak",       32'h104, 0, 32'h200, 0, 0, 32'd2);
    step(); drive(32'h180, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    expect_out("stall",      32'h180, 0, 32'h184, 0, 1, 32'd2);
    step(); drive(32'h180, 1, 1, 1, 32'h244, 1, 32'h300, 0, 32'h0);
    expect_out("stall_mp",   32'h300, 0, 32'h184, 1, 0, 32'd2);
    step(); drive(32'h100, 0, 1, 1, 32'h100, 1, 32'h200, 0, 32'h0);
    expect_out("retrain1",   32'h200, 0, 32'h200, 1, 0, 32'd3);
    step(); drive(32'h100, 0, 1, 1, 32'h100, 1, 32'h200, 0, 32'h0);
    expect_out("retrain2",   32'h200, 0, 32'h200, 1, 0, 32'd4);
    step(); drive(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    expect_out("retaken",    32'h200, 1, 32'h200, 0, 0, 32'd5);
    step(); drive(32'h100, 0, 1, 0, 32'h100, 0, 32'h0,   1, 32'h200);
    expect_out("alias",      32'h104, 1, 32'h200, 1, 0, 32'd5);
    step(); drive(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    expect_out("alias_gone", 32'h104, 0, 32'h104, 0, 0, 32'd6);
    step(); drive(32'h000, 0, 1, 1, 32'h100, 1, 32'h200, 0, 32'h0);
    expect_out("conf_a",     32'h200, 0, 32'h004, 1, 0, 32'd6);
    step(); drive(32'h000, 0, 1, 1, 32'h140, 1, 32'h400, 0, 32'h0);
    expect_out("conf_b",     32'h400, 0, 32'h004, 1, 0, 32'd7);
    step(); drive(32'h100, 0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    expect_out("conf_miss",  32'h104, 0, 32'h104, 0, 0, 32'd8);
    step(); drive(32'h140, 0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    expect_out("conf_hit",   32'h400, 1, 32'h400, 0, 0, 32'd8);
    step(); drive(32'hFFFF_FFFC, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    expect_out("wrap",       32'h0,   0, 32'h0,   0, 0, 32'd8);
    step(); drive(32'h140, 0, 1, 0, 32'h500, 0, 32'h0,   0, 32'h0);
    expect_out("nb_ok",      32'h400, 1, 32'h400, 0, 0, 32'd8);

    // Asynchronous reset between edges clears table and counter at once
    step(); drive(32'h140, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    #2 rst_i = 1'b0;
    expect_out("rst_mid",    32'h144, 0, 32'h144, 0, 0, 32'd0);
    step(); rst_i = 1'b1;
    expect_out("post_rst",   32'h144, 0, 32'h144, 0, 0, 32'd0);

    // Bounded drain of the scoreboard
    repeat (3) @(negedge clk_i);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
